// File: rtl/acq_pkg.sv
// Shared command byte codes, controller state encoding and command decode helper.
package acq_pkg;

    localparam logic [7:0] CODE_CAPTURE = 8'h53;
    localparam logic [7:0] CODE_READ    = 8'h52;
    localparam logic [7:0] CODE_ABORT   = 8'h41;

    localparam int CNT_W = 24;

    typedef enum logic [3:0] {
        IDLE,
        CAPTURE,
        SERIAL,
        PREFETCH,
        RD,
        LATCH,
        TX_HI,
        TX_LO,
        TX_WAIT
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CAPTURE,
        CMD_READ,
        CMD_ABORT
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic i_vld, input logic [7:0] i_byte);
        cmd_t v_cmd;
        v_cmd = CMD_NONE;
        if (i_vld) begin
            case (i_byte)
                CODE_CAPTURE: v_cmd = CMD_CAPTURE;
                CODE_READ:    v_cmd = CMD_READ;
                CODE_ABORT:   v_cmd = CMD_ABORT;
                default:      v_cmd = CMD_NONE;
            endcase
        end
        return v_cmd;
    endfunction

endpackage

// File: rtl/acq_tx_seq.sv
// UART byte-send handshake: fires when requested and the line is free; tx_en/tx_data one cycle after o_fire.
// tx_busy is disregarded for the two cycles following each tx_en, then must read low before the next send.
module acq_tx_seq (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       tx_busy,
    output logic       o_fire,
    output logic       tx_en,
    output logic [7:0] tx_data
);

    logic [1:0] r_guard;
    logic       r_tx_en;
    logic [7:0] r_tx_data;

    // Guard covers the tx_en cycle itself plus two more, so back-to-back strobes are impossible.
    assign o_fire  = i_req && (r_guard == 2'd0) && !tx_busy;
    assign tx_en   = r_tx_en;
    assign tx_data = r_tx_data;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_guard   <= 2'd0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_en <= o_fire;
            if (o_fire) begin
                r_tx_data <= i_byte;
                r_guard   <= 2'd3;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
        end
    end

endmodule

// File: rtl/acq_ctrl.sv
// ADC capture to SDRAM write FIFO and UART readback controller, driven by single-byte commands.
// Load/strobe outputs register one cycle after the deciding edge; UART sends stall on tx_busy.
module acq_ctrl
    import acq_pkg::*;
#(
    parameter int CH_NUM      = 8,
    parameter int DEPTH       = 32768,
    parameter int RD_PREFETCH = 64
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         sdram_init_done,
    input  logic         cmd_done,
    input  logic [7:0]   cmd_data,
    input  logic         sample_valid,
    input  logic [127:0] ad_ch_bus,
    output logic         wr_load,
    output logic         wr_en,
    output logic [15:0]  wr_data,
    output logic         rd_load,
    output logic         rd_en,
    input  logic [15:0]  rd_data,
    input  logic         tx_busy,
    output logic         tx_en,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         overflow
);

    localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);
    localparam logic [2:0]       LAST_CH = 3'(CH_NUM - 1);
    localparam int               PF_W    = (RD_PREFETCH > 1) ? $clog2(RD_PREFETCH) : 1;
    localparam logic [PF_W-1:0]  LAST_PF = PF_W'(RD_PREFETCH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_sample;
    logic [2:0]         r_ch_idx;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [PF_W-1:0]    r_pf_cnt;
    logic [15:0]        r_rd_word;
    logic               r_wr_load;
    logic               r_rd_load;
    logic               r_overflow;

    cmd_t               w_cmd;
    logic               w_abort;
    logic               w_tx_req;
    logic               w_tx_fire;
    logic [7:0]         w_tx_byte;

    assign w_cmd   = decode_cmd(cmd_done, cmd_data);
    assign w_abort = (w_cmd == CMD_ABORT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd == CMD_CAPTURE && sdram_init_done) begin
                    w_state_nxt = CAPTURE;
                end else if (w_cmd == CMD_READ && r_word_cnt != '0) begin
                    w_state_nxt = PREFETCH;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    w_state_nxt = SERIAL;
                end
            end
            SERIAL: begin
                if (r_ch_idx == LAST_CH) begin
                    w_state_nxt = (r_word_cnt + 1'b1 == DEPTH_W) ? IDLE : CAPTURE;
                end
            end
            PREFETCH: begin
                if (r_pf_cnt == LAST_PF) begin
                    w_state_nxt = RD;
                end
            end
            RD:      w_state_nxt = LATCH;
            LATCH:   w_state_nxt = TX_HI;
            TX_HI: begin
                if (w_tx_fire) begin
                    w_state_nxt = TX_LO;
                end
            end
            TX_LO: begin
                if (w_tx_fire) begin
                    w_state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                w_state_nxt = (r_rd_cnt + 1'b1 == r_word_cnt) ? IDLE : RD;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_sample   <= '0;
            r_ch_idx   <= 3'd0;
            r_word_cnt <= '0;
            r_rd_cnt   <= '0;
            r_pf_cnt   <= '0;
            r_rd_word  <= 16'h0000;
            r_wr_load  <= 1'b0;
            r_rd_load  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_load <= 1'b0;
            r_rd_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_state_nxt == CAPTURE) begin
                        r_wr_load  <= 1'b1;
                        r_word_cnt <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_state_nxt == PREFETCH) begin
                        r_rd_load <= 1'b1;
                        r_rd_cnt  <= '0;
                        r_pf_cnt  <= '0;
                    end
                end
                CAPTURE: begin
                    if (w_state_nxt == SERIAL) begin
                        r_sample <= ad_ch_bus;
                        r_ch_idx <= 3'd0;
                    end
                end
                SERIAL: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_ch_idx   <= r_ch_idx + 3'd1;
                    if (sample_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                PREFETCH: r_pf_cnt  <= r_pf_cnt + 1'b1;
                LATCH:    r_rd_word <= rd_data;
                TX_WAIT:  r_rd_cnt  <= r_rd_cnt + 1'b1;
                default: ;
            endcase
            // Abort discards the capture length so a later readback has nothing to dump.
            if (w_abort) begin
                r_word_cnt <= '0;
            end
        end
    end

    assign w_tx_req  = (r_state == TX_HI || r_state == TX_LO) && !w_abort;
    assign w_tx_byte = (r_state == TX_HI) ? r_rd_word[15:8] : r_rd_word[7:0];

    acq_tx_seq u_tx_seq (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_req     (w_tx_req),
        .i_byte    (w_tx_byte),
        .tx_busy   (tx_busy),
        .o_fire    (w_tx_fire),
        .tx_en     (tx_en),
        .tx_data   (tx_data)
    );

    assign wr_en    = (r_state == SERIAL);
    assign wr_data  = wr_en ? r_sample[{r_ch_idx, 4'd0} +: 16] : 16'h0000;
    assign rd_en    = (r_state == RD);
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;
    assign wr_load  = r_wr_load;
    assign rd_load  = r_rd_load;

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl with DEPTH=16, CH_NUM=8, RD_PREFETCH=8.
module tb_acq_ctrl;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         sdram_init_done;
    logic         cmd_done;
    logic [7:0]   cmd_data;
    logic         sample_valid;
    logic [127:0] ad_ch_bus;
    logic         wr_load;
    logic         wr_en;
    logic [15:0]  wr_data;
    logic         rd_load;
    logic         rd_en;
    logic [15:0]  rd_data;
    logic         tx_busy;
    logic         tx_en;
    logic [7:0]   tx_data;
    logic         busy;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    acq_ctrl #(
        .CH_NUM      (8),
        .DEPTH       (16),
        .RD_PREFETCH (8)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .sdram_init_done (sdram_init_done),
        .cmd_done        (cmd_done),
        .cmd_data        (cmd_data),
        .sample_valid    (sample_valid),
        .ad_ch_bus       (ad_ch_bus),
        .wr_load         (wr_load),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_load         (rd_load),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .tx_busy         (tx_busy),
        .tx_en           (tx_en),
        .tx_data         (tx_data),
        .busy            (busy),
        .overflow        (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    int          tx_cnt  = 0;
    int          rdl_cnt = 0;
    int          act_cnt = 0;
    int          dbl_cnt = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic        p_wrl = 1'b0;
    logic        p_rdl = 1'b0;
    logic        p_tx  = 1'b0;

    always @(negedge sys_clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            wr_q.push_back(wr_data);
        end
        if (rd_en === 1'b1) rd_cnt++;
        if (rd_load === 1'b1) rdl_cnt++;
        if (tx_en === 1'b1) begin
            tx_cnt++;
            tx_q.push_back(tx_data);
        end
        if ((wr_load === 1'b1 && p_wrl) || (rd_load === 1'b1 && p_rdl) || (tx_en === 1'b1 && p_tx))
            dbl_cnt++;
        if (wr_load === 1'b1 || wr_en === 1'b1 || rd_load === 1'b1 || rd_en === 1'b1 || tx_en === 1'b1)
            act_cnt++;
        p_wrl = (wr_load === 1'b1);
        p_rdl = (rd_load === 1'b1);
        p_tx  = (tx_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_data = b;
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
    endtask

    task automatic pulse_sample(input logic [127:0] v);
        ad_ch_bus    = v;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    function automatic logic [127:0] mk(input logic [15:0] base);
        logic [127:0] v;
        v = '0;
        for (int n = 1; n <= 8; n++) v[16*n-1 -: 16] = base + 16'(n);
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({wr_load, wr_en, rd_load, rd_en, tx_en, busy, overflow});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b_wr, b_rd, b_tx, b_rdl, b_act, b_wq, b_tq, errs;

        sys_rst_n       = 1'b0;
        sdram_init_done = 1'b0;
        cmd_done        = 1'b0;
        cmd_data        = 8'h00;
        sample_valid    = 1'b0;
        ad_ch_bus       = '0;
        rd_data         = 16'hABCD;
        tx_busy         = 1'b0;
        tick(3);
        chk("reset_outputs", outs(), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'h00);
        chk("reset_wr_data", 32'(wr_data), 32'h0);
        sys_rst_n = 1'b1;
        tick(2);

        // Commands that must be ignored: S without SDRAM, unknown byte, R with nothing captured.
        b_act = act_cnt;
        send_cmd(8'h53);
        send_cmd(8'h55);
        send_cmd(8'h52);
        tick(5);
        chk("ignored_cmds_activity", 32'(act_cnt - b_act), 32'd0);
        chk("ignored_cmds_busy", 32'(busy), 32'd0);

        // Full capture: two samples 20 cycles apart fill DEPTH=16.
        sdram_init_done = 1'b1;
        b_wr = wr_cnt;
        b_wq = wr_q.size();
        send_cmd(8'h53);
        chk("capture_wr_load", 32'(wr_load), 32'd1);
        chk("capture_busy", 32'(busy), 32'd1);
        tick(1);
        chk("capture_wr_load_single", 32'(wr_load), 32'd0);
        pulse_sample(mk(16'h1000));
        tick(19);
        pulse_sample(mk(16'h1000));
        tick(7);
        chk("capture_last_word_busy", 32'({wr_en, busy}), 32'b11);
        tick(1);
        chk("capture_end_idle", 32'({wr_en, busy}), 32'b00);
        chk("capture_wr_cnt", 32'(wr_cnt - b_wr), 32'd16);
        errs = 0;
        for (int i = 0; i < 16; i++)
            if (wr_q[b_wq + i] !== 16'h1001 + 16'(i % 8)) errs++;
        chk("capture_word_order", 32'(errs), 32'd0);
        chk("capture_no_overflow", 32'(overflow), 32'd0);

        // Readback of 16 words, UART held busy at first.
        tx_busy = 1'b1;
        b_rd  = rd_cnt;
        b_tx  = tx_cnt;
        b_rdl = rdl_cnt;
        b_tq  = tx_q.size();
        send_cmd(8'h52);
        chk("read_rd_load", 32'(rd_load), 32'd1);
        tick(1);
        chk("read_rd_load_single", 32'(rd_load), 32'd0);
        tick(6);
        chk("read_prefetch_no_rd_en", 32'(rd_en), 32'd0);
        tick(1);
        chk("read_first_rd_en", 32'(rd_en), 32'd1);
        tick(20);
        chk("read_stall_tx_cnt", 32'(tx_cnt - b_tx), 32'd0);
        chk("read_stall_rd_cnt", 32'(rd_cnt - b_rd), 32'd1);
        tx_busy = 1'b0;
        for (int i = 0; i < 3000 && busy === 1'b1; i++) tick(1);
        chk("read_done_idle", 32'(busy), 32'd0);
        chk("read_rd_en_cnt", 32'(rd_cnt - b_rd), 32'd16);
        chk("read_tx_en_cnt", 32'(tx_cnt - b_tx), 32'd32);
        chk("read_rd_load_cnt", 32'(rdl_cnt - b_rdl), 32'd1);
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (tx_q[b_tq + i] !== ((i % 2 == 0) ? 8'hAB : 8'hCD)) errs++;
        chk("read_byte_order", 32'(errs), 32'd0);
        chk("read_tx_data_held", 32'(tx_data), 32'hCD);

        // Second sample 3 cycles after the first lands in SERIAL and is dropped.
        b_wr = wr_cnt;
        b_wq = wr_q.size();
        send_cmd(8'h53);
        pulse_sample(mk(16'h1000));
        tick(2);
        pulse_sample(mk(16'h2000));
        tick(10);
        chk("drop_wr_cnt", 32'(wr_cnt - b_wr), 32'd8);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_still_capturing", 32'(busy), 32'd1);
        errs = 0;
        for (int i = 0; i < 8; i++)
            if (wr_q[b_wq + i] !== 16'h1001 + 16'(i)) errs++;
        chk("drop_first_sample_kept", 32'(errs), 32'd0);

        // Abort during the third word of a sample.
        b_wr = wr_cnt;
        pulse_sample(mk(16'h1000));
        tick(2);
        send_cmd(8'h41);
        chk("abort_outputs", 32'({wr_en, busy}), 32'b00);
        tick(2);
        chk("abort_wr_cnt", 32'(wr_cnt - b_wr), 32'd3);
        chk("abort_keeps_overflow", 32'(overflow), 32'd1);
        b_rd = rd_cnt;
        send_cmd(8'h52);
        chk("abort_read_ignored_load", 32'(rd_load), 32'd0);
        tick(10);
        chk("abort_read_ignored", 32'({rd_cnt - b_rd != 0, busy}), 32'd0);

        // Reset while waiting in TX_HI.
        send_cmd(8'h53);
        pulse_sample(mk(16'h3000));
        tick(19);
        pulse_sample(mk(16'h3000));
        tick(10);
        tx_busy = 1'b1;
        b_tx = tx_cnt;
        send_cmd(8'h52);
        tick(12);
        chk("txhi_wait_busy", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        tx_busy   = 1'b0;
        tick(1);
        chk("midreset_outputs", outs(), 32'd0);
        chk("midreset_tx_data", 32'(tx_data), 32'h00);
        tick(1);
        sys_rst_n = 1'b1;
        tick(2);
        chk("midreset_no_tx", 32'(tx_cnt - b_tx), 32'd0);
        send_cmd(8'h53);
        chk("fresh_wr_load", 32'(wr_load), 32'd1);
        send_cmd(8'h53);
        chk("s_outside_idle_ignored", 32'(wr_load), 32'd0);
        pulse_sample(mk(16'h1000));
        chk("fresh_first_word", 32'({wr_en, wr_data}), 32'h1_1001);
        send_cmd(8'h41);
        tick(2);
        chk("final_idle", 32'(busy), 32'd0);
        chk("no_double_pulses", 32'(dbl_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_ctrl.md
ACQ_CTRL -- requirements
Module: acq_ctrl

Interface
REQ-001 Parameter CH_NUM, default 8: ADC channels written per sample; 1..8.
REQ-002 Parameter DEPTH, default 32768: 16-bit words per capture; multiple of CH_NUM; 24-bit count.
REQ-003 Parameter RD_PREFETCH, default 64: wait cycles after rd_load before first rd_en.
REQ-004 Ports, one per line: name  direction  width  meaning.
- sys_clk  in  1  single clock (50 MHz); all logic on its rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- sdram_init_done  in  1  SDRAM ready; start is ignored while low.
- cmd_done  in  1  one-cycle strobe from the UART receiver.
- cmd_data  in  8  received command byte, valid with cmd_done.
- sample_valid  in  1  one-cycle strobe; ad_ch_bus holds a new sample.
- ad_ch_bus  in  128  channel n in bits [16n-1:16n-16], channel 1 in [15:0].
- wr_load  out  1  one-cycle pulse; resets the SDRAM write address.
- wr_en  out  1  write-FIFO write strobe.
- wr_data  out  16  write-FIFO data, valid with wr_en.
- rd_load  out  1  one-cycle pulse; resets the SDRAM read address.
- rd_en  out  1  read-FIFO read strobe.
- rd_data  in  16  read-FIFO data, valid the cycle after rd_en.
- tx_busy  in  1  UART transmitter busy.
- tx_en  out  1  one-cycle UART send strobe.
- tx_data  out  8  UART byte, held stable from tx_en until the next tx_en.
- busy  out  1  high in every state except IDLE.
- overflow  out  1  sticky; a sample was dropped during capture.

Function
REQ-005 Commands: 0x53 'S' = capture, 0x52 'R' = readback, 0x41 'A' = abort; all other bytes are ignored.
REQ-006 States: IDLE, CAPTURE, SERIAL, PREFETCH, RD, LATCH, TX_HI, TX_LO, TX_WAIT.
REQ-007 IDLE + 'S' + sdram_init_done: pulse wr_load, clear word_cnt and overflow, go to CAPTURE; 'S' while sdram_init_done is low is ignored.
REQ-008 CAPTURE + sample_valid: latch ad_ch_bus, go to SERIAL.
REQ-009 SERIAL: wr_en high for CH_NUM consecutive cycles with channels 1..CH_NUM in order; word_cnt increments on each wr_en.
REQ-010 sample_valid in SERIAL: the sample is dropped, overflow is set, and serialization continues unchanged.
REQ-011 After the last wr_en: go to IDLE when word_cnt == DEPTH, otherwise return to CAPTURE; words are never written beyond DEPTH.
REQ-012 IDLE + 'R' + captured word_cnt > 0: pulse rd_load, go to PREFETCH for RD_PREFETCH cycles, then RD; 'R' with word_cnt == 0 is ignored.
REQ-013 RD: rd_en high for one cycle; LATCH captures rd_data on the next cycle.
REQ-014 Byte transmit in TX_HI / TX_LO: wait for tx_busy low, pulse tx_en with the high byte (TX_HI) then the low byte (TX_LO).
REQ-015 Transmit guard: tx_busy is ignored for 2 cycles after each tx_en, then the block waits for tx_busy low.
REQ-016 After the low byte: rd_cnt increments; go to IDLE when rd_cnt == word_cnt, else to RD.
REQ-017 'A' in any state: IDLE on the next edge; wr_en, rd_en and tx_en are low from that edge; word_cnt is cleared; overflow is kept.
REQ-018 'S' or 'R' received outside IDLE is ignored; a cmd_done in the same cycle as sample_valid is decoded normally.
REQ-019 wr_load, rd_load and tx_en are never high for more than one consecutive cycle.

Reset
REQ-020 While sys_rst_n is low at a sys_clk edge: state = IDLE; all outputs 0 (tx_data = 0x00); word_cnt, rd_cnt and the channel index are 0.
REQ-021 Reset mid-capture or mid-dump takes effect on the same edge, with no residual strobes.

Structure
REQ-022 Command byte codes and the state encoding are defined in the shared package acq_pkg.
REQ-023 The byte-send handshake of REQ-014/REQ-015 is implemented in sub-module acq_tx_seq.

Verification
REQ-024 'S', then 4096 sample_valid pulses spaced 20 cycles, ch n = 0x1000+n: 32768 wr_en, words 0x1001..0x1008 repeating; busy falls after the final word.
REQ-025 Two sample_valid pulses 3 cycles apart in CAPTURE: second sample dropped, overflow = 1, exactly 8 wr_en.
REQ-026 'R' after a 16-word capture with rd_data = 0xABCD: rd_load, 16 rd_en, 32 tx_en; bytes in order 0xAB, 0xCD.
REQ-027 'A' while in SERIAL at the 3rd word: wr_en is low from the next edge, busy = 0; a following 'R' is ignored.
REQ-028 'S' with sdram_init_done = 0, and 0x55 sent in IDLE: no output activity.
REQ-029 sys_rst_n low during TX_HI: all outputs 0 on the next edge; a following 'S' starts a fresh capture.
